// File: rtl/multiport_memory.sv
`default_nettype none
// ============================================================================
// Module   : multiport_memory
// Purpose  : Single-port word memory shared by NCH toggle-handshake requesters
//            through a round-robin arbiter, with optional wait states.
// Revision : 1.0  initial release
// ============================================================================
module multiport_memory #(
    parameter int NCH         = 2,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 32768,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH*ADDR_W-1:0]    addr,
    input  logic [NCH*2-1:0]         cmd,
    input  logic [NCH-1:0]           run,
    input  logic [NCH*DATA_W-1:0]    wr_data,
    output logic [NCH*DATA_W-1:0]    rd_data,
    output logic [NCH-1:0]           done,
    output logic [NCH-1:0]           err
);

    localparam int         c_GW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int         c_MW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [1:0] c_CMD_READ  = 2'b01;
    localparam logic [1:0] c_CMD_WRITE = 2'b10;
    localparam logic [1:0] c_CMD_SWAP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_wcnt;
    logic [c_GW-1:0]     r_rr;
    logic [c_GW-1:0]     r_gnt;
    logic [c_GW-1:0]     w_sel;
    logic                w_found;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_cmd;
    logic [DATA_W-1:0]   r_wd;
    logic [NCH-1:0]      r_done;
    logic [NCH-1:0]      r_err;
    logic [NCH-1:0]      w_pend;
    logic [DATA_W-1:0]   r_rd  [NCH];
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_oor;
    logic                w_rd_op;
    logic                w_wr_op;
    logic [c_MW-1:0]     w_idx;
    logic                w_grant;

    assign w_pend  = run ^ r_done;
    assign w_oor   = ({1'b0, r_addr} >= (ADDR_W + 1)'(DEPTH));
    assign w_idx   = r_addr[c_MW-1:0];
    assign w_rd_op = (r_cmd == c_CMD_READ)  || (r_cmd == c_CMD_SWAP);
    assign w_wr_op = (r_cmd == c_CMD_WRITE) || (r_cmd == c_CMD_SWAP);
    assign w_grant = (r_state == S_IDLE) && w_found;

    // Scan from the highest offset down so the lowest offset from r_rr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_pend[(int'(r_rr) + k) % NCH]) begin
                w_found = 1'b1;
                w_sel   = c_GW'((int'(r_rr) + k) % NCH);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (r_wcnt == c_WAIT_LAST) w_next = S_ACCESS;
            S_ACCESS: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Request capture; later changes on the granted channel are ignored.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_gnt  <= w_sel;
            r_addr <= addr[w_sel*ADDR_W +: ADDR_W];
            r_cmd  <= cmd[w_sel*2 +: 2];
            r_wd   <= wr_data[w_sel*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt <= '0;
            r_rr   <= '0;
            r_done <= '0;
            r_err  <= '0;
            for (int i = 0; i < NCH; i++) r_rd[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_wcnt <= '0;
                        r_rr   <= (w_sel == c_GW'(NCH - 1)) ? '0 : w_sel + 1'b1;
                    end
                end
                S_WAIT: r_wcnt <= r_wcnt + 4'd1;
                S_ACCESS: begin
                    r_done[r_gnt] <= ~r_done[r_gnt];
                    r_err[r_gnt]  <= w_oor;
                    if (w_rd_op) r_rd[r_gnt] <= w_oor ? '1 : r_mem[w_idx];
                end
                default: r_wcnt <= '0;
            endcase
        end
    end

    // Memory array has no reset so its contents survive it.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_ACCESS) && w_wr_op && !w_oor)
            r_mem[w_idx] <= r_wd;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_out
        assign rd_data[i*DATA_W +: DATA_W] = r_rd[i];
    end
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: doc/multiport_memory.md
MULTIPORT_MEMORY -- requirements
Module: multiport_memory

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of requester channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, meaning word width.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-004 SHALL have parameter DEPTH, default 32768, meaning words implemented (DEPTH <= 2**ADDR_W).
REQ-005 SHALL have parameter WAIT_STATES, default 0, meaning extra cycles inserted before each access (0..15).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port addr, input, NCH*ADDR_W, per-channel word address (channel i at slice i).
REQ-009 SHALL have port cmd, input, NCH*2, per-channel command: 00 nop, 01 read, 10 write, 11 swap.
REQ-010 SHALL have port run, input, NCH, per-channel request toggle.
REQ-011 SHALL have port wr_data, input, NCH*DATA_W, per-channel write data.
REQ-012 SHALL have port rd_data, output, NCH*DATA_W, per-channel registered read data.
REQ-013 SHALL have port done, output, NCH, per-channel completion toggle.
REQ-014 SHALL have port err, output, NCH, per-channel registered error flag of last completed access.

Function
REQ-015 SHALL treat channel i as pending whenever run[i] != done[i]; a requester toggles run[i] once, then waits for done[i] == run[i] before changing addr/cmd/wr_data or toggling again.
REQ-016 SHALL run FSM IDLE -> WAIT -> ACCESS -> IDLE; IDLE -> ACCESS directly when WAIT_STATES = 0.
REQ-017 SHALL, in IDLE with any pending channel, grant one channel by round-robin starting at rr_ptr, latch its addr/cmd/wr_data, and leave IDLE on that edge.
REQ-018 SHALL set rr_ptr to (granted+1) mod NCH at each grant, so a continuously pending channel waits at most NCH-1 other accesses.
REQ-019 SHALL stay in WAIT exactly WAIT_STATES cycles, counted by a 4-bit counter.
REQ-020 SHALL, in ACCESS: read -> rd_data[g] <= mem[a]; write -> mem[a] <= wd; swap -> rd_data[g] <= old mem[a] and mem[a] <= wd on the same edge; nop -> no memory or rd_data change.
REQ-021 SHALL, in ACCESS, toggle done[g], set err[g], and return to IDLE; channel-to-done latency from the run toggle being sampled in IDLE is WAIT_STATES+2 edges; back-to-back throughput is one access per WAIT_STATES+2 cycles.
REQ-022 SHALL treat an address >= DEPTH as out of range: memory unchanged, rd_data[g] <= all ones for read/swap, err[g] <= 1, done[g] still toggles; otherwise err[g] <= 0.
REQ-023 SHALL ignore input changes on the granted channel after the latch, and SHALL leave done, rd_data and err of non-granted channels unchanged.
REQ-024 SHALL return to IDLE only from ACCESS; a channel becoming pending during WAIT/ACCESS is considered at the next IDLE.
REQ-025 SHALL, when only one channel is pending, grant it regardless of rr_ptr.

Reset
REQ-026 SHALL on reset set state IDLE, wait counter 0, rr_ptr 0, done all 0, err all 0, rd_data all 0.
REQ-027 SHALL NOT clear memory contents on reset; contents survive reset.
REQ-028 SHALL, on reset during WAIT or ACCESS, abort the access with no memory write and no done toggle.

Verification
REQ-029 SHALL verify: NCH=2, WAIT_STATES=0, ch0 write 0x1234 to 0x000F, then read 0x000F -> rd_data[0]=0x1234, done[0] toggles 2 edges after each run toggle, err[0]=0.
REQ-030 SHALL verify: ch0 and ch1 toggle run on the same edge after reset -> ch0 completes first, ch1 next access; repeated simultaneous requests alternate 0,1,0,1.
REQ-031 SHALL verify: WAIT_STATES=3, read -> done toggles exactly 5 edges after the run toggle is sampled.
REQ-032 SHALL verify: mem[0x0010]=0x00AA, swap with wr_data 0x5555 -> rd_data=0x00AA; subsequent read returns 0x5555.
REQ-033 SHALL verify: DEPTH=1024, write to 0x0400 -> err=1, done toggles, mem[0x0000] unchanged; read 0x0400 -> rd_data=0xFFFF, err=1.
REQ-034 SHALL verify: reset asserted in WAIT of a write to 0x0020 -> mem[0x0020] unchanged, done=0; earlier contents of 0x000F still readable after reset.
